// File: rtl/sm_gpio_ctrl_pkg.sv
// sm_gpio_ctrl_pkg: register offsets and defaults shared by the GPIO controller and its users.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: 6-bit register offsets inside the 64-byte GPIO window, default decode base, bus width.
package sm_gpio_ctrl_pkg;

  localparam int          SM_BUS_W             = 32;
  localparam logic [15:0] SM_GPIO_BASE_DEFAULT = 16'hbeb0;

  localparam logic [5:0] SM_GPIO_OFS_OUT      = 6'h00;
  localparam logic [5:0] SM_GPIO_OFS_DIR      = 6'h04;
  localparam logic [5:0] SM_GPIO_OFS_IN       = 6'h08;
  localparam logic [5:0] SM_GPIO_OFS_SET      = 6'h0C;
  localparam logic [5:0] SM_GPIO_OFS_CLR      = 6'h10;
  localparam logic [5:0] SM_GPIO_OFS_TGL      = 6'h14;
  localparam logic [5:0] SM_GPIO_OFS_RISE_EN  = 6'h18;
  localparam logic [5:0] SM_GPIO_OFS_FALL_EN  = 6'h1C;
  localparam logic [5:0] SM_GPIO_OFS_IRQ_STAT = 6'h20;

endpackage

// File: rtl/sm_gpio_ctrl_if.sv
// sm_gpio_ctrl_if: schoolMIPS data-bus slice seen by the GPIO controller.
// Latency: write committed on the clk edge with bWe high; read data combinational.
// Backpressure: none, the bus never stalls.
// Signals: bAddr (byte address), bWe (write strobe), bWData (write data), bRData (read data).
interface sm_gpio_ctrl_if;
  import sm_gpio_ctrl_pkg::*;

  logic [SM_BUS_W-1:0] bAddr;
  logic                bWe;
  logic [SM_BUS_W-1:0] bWData;
  logic [SM_BUS_W-1:0] bRData;

  modport master (output bAddr, output bWe, output bWData, input bRData);
  modport slave  (input bAddr, input bWe, input bWData, output bRData);
endinterface

// File: rtl/sm_gpio_debounce.sv
// sm_gpio_debounce: single-pin stability filter placed after the input synchroniser.
// Latency: output follows din after DB_CYCLES consecutive cycles of disagreement.
// Backpressure: none.
// Ports: clk, rst_n (async active-low), din (synchronised pin), dout (filtered pin, resets to 0).
module sm_gpio_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Any cycle where din agrees with the filtered value restarts the window,
  // so a glitch shorter than DB_CYCLES never reaches dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CW'(DB_CYCLES - 1)) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sm_gpio_ctrl.sv
// sm_gpio_ctrl: memory-mapped GPIO with direction, SET/CLR/TGL, sync, edge capture, W1C status, level irq.
// Latency: writes visible next cycle; pin edge -> IRQ_STAT 3 clk (+DB_CYCLES with SM_GPIO_DEBOUNCE_EN), irq +1.
// Backpressure: none, zero wait states on the bus.
// Ports: clk, rst_n, bus (slave: bAddr/bWe/bWData/bRData), gpio_in, gpio_out, gpio_oe, irq.
// Build option: define SM_GPIO_DEBOUNCE_EN to insert a per-pin debouncer between the synchroniser and IN/edge logic.
module sm_gpio_ctrl
  import sm_gpio_ctrl_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [15:0] BASE_ADDR = SM_GPIO_BASE_DEFAULT,
  parameter int          DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sm_gpio_ctrl_if.slave    bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [5:0]       ofs;
  logic             hit;
  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, stat_q;
  logic [WIDTH-1:0] s1, s2, s3, filt;
  logic [WIDTH-1:0] rise, fall, w1c;
  logic [WIDTH-1:0] rdata;
  logic             irq_q;
  logic             unused_bits;

  // The controller owns a 64-byte aligned window; the low 6 bits of
  // BASE_ADDR are ignored and bAddr[5:0] is the register offset.
  assign hit = (bus.bAddr[15:6] == BASE_ADDR[15:6]);
  assign ofs = bus.bAddr[5:0];
  assign wr  = bus.bWe && hit;
  assign wd  = bus.bWData[WIDTH-1:0];

  assign unused_bits = ^{bus.bAddr[31:16], bus.bWData};

  // 2-flop synchroniser; s3 holds the previous filtered value for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= gpio_in;
      s2 <= s1;
      s3 <= filt;
    end
  end

`ifdef SM_GPIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    sm_gpio_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (s2[i]),
      .dout (filt[i])
    );
  end
`else
  assign filt = s2;
`endif

  assign rise = filt & ~s3 & rise_en_q;
  assign fall = ~filt & s3 & fall_en_q;
  assign w1c  = (wr && ofs == SM_GPIO_OFS_IRQ_STAT) ? wd : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (wr) begin
        case (ofs)
          SM_GPIO_OFS_OUT:     out_q     <= wd;
          SM_GPIO_OFS_SET:     out_q     <= out_q | wd;
          SM_GPIO_OFS_CLR:     out_q     <= out_q & ~wd;
          SM_GPIO_OFS_TGL:     out_q     <= out_q ^ wd;
          SM_GPIO_OFS_DIR:     dir_q     <= wd;
          SM_GPIO_OFS_RISE_EN: rise_en_q <= wd;
          SM_GPIO_OFS_FALL_EN: fall_en_q <= wd;
          default: ;
        endcase
      end
      // A capture in the same cycle as its W1C keeps the bit set, so no edge is lost.
      stat_q <= (stat_q & ~w1c) | rise | fall;
      irq_q  <= |(stat_q & (rise_en_q | fall_en_q));
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (ofs)
        SM_GPIO_OFS_OUT:      rdata = out_q;
        SM_GPIO_OFS_DIR:      rdata = dir_q;
        SM_GPIO_OFS_IN:       rdata = filt;
        SM_GPIO_OFS_RISE_EN:  rdata = rise_en_q;
        SM_GPIO_OFS_FALL_EN:  rdata = fall_en_q;
        SM_GPIO_OFS_IRQ_STAT: rdata = stat_q;
        default:              rdata = '0;
      endcase
    end
  end

  assign bus.bRData = SM_BUS_W'(rdata);
  assign gpio_out   = out_q;
  assign gpio_oe    = dir_q;
  assign irq        = irq_q;

endmodule
